// File: rtl/fastbus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fastbus_pkg
// Description : Shared state encoding and constants for the fast-chip bus
//               initiator.
// Revision    : 1.0 - initial release
// ============================================================================
package fastbus_pkg;

    localparam int c_word_w      = 16;
    localparam int c_timeout_def = 255;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLAIM = 3'd1,
        ST_WAIT  = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } fb_state_t;

endpackage
`default_nettype wire

// File: rtl/fastbus_timer.sv
`default_nettype none
// ============================================================================
// Module      : fastbus_timer
// Description : Wait-state counter; expires once it reaches TIMEOUT-1.
// Revision    : 1.0 - initial release
// ============================================================================
module fastbus_timer #(
    parameter int TIMEOUT   = 255,
    parameter int TIMEOUT_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam logic [TIMEOUT_W-1:0] c_last = TIMEOUT_W'(TIMEOUT - 1);

    logic [TIMEOUT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/fastbus_initiator.sv
`default_nettype none
// ============================================================================
// Module      : fastbus_initiator
// Description : Fast-chip register bus master; splits 32-bit requests into two
//               16-bit cycles and reports ack / miss / timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module fastbus_initiator
    import fastbus_pkg::*;
#(
    parameter int TIMEOUT   = c_timeout_def,
    parameter int TIMEOUT_W = 8
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                req,
    input  logic [23:0]         req_addr,
    input  logic                req_wr,
    input  logic                req_long,
    input  logic                req_uds,
    input  logic                req_lds,
    input  logic [31:0]         req_wdata,
    output logic                busy,
    output logic                ack,
    output logic                miss,
    output logic                err,
    output logic [31:0]         rdata,
    output logic                sel,
    output logic [23:0]         addr,
    output logic [c_word_w-1:0] din,
    input  logic [c_word_w-1:0] dout,
    output logic                uds,
    output logic                lds,
    output logic                rnw,
    output logic                longword,
    input  logic                sel_ack,
    input  logic                ready
);

    fb_state_t           r_state, w_state;
    logic                r_sel, w_sel;
    logic [23:0]         r_addr, w_addr;
    logic [c_word_w-1:0] r_din, w_din;
    logic [c_word_w-1:0] r_wlo, w_wlo;
    logic                r_uds, w_uds;
    logic                r_lds, w_lds;
    logic                r_rnw, w_rnw;
    logic                r_long, w_long;
    logic                r_half, w_half;
    logic [31:0]         r_rdata, w_rdata;
    logic                r_miss, w_miss;
    logic                r_err, w_err;
    logic                w_word_done;
    logic                w_expire;

    fastbus_timer #(
        .TIMEOUT   (TIMEOUT),
        .TIMEOUT_W (TIMEOUT_W)
    ) u_timer (
        .clk      (clk_sys),
        .rst      (reset),
        .i_clear  (r_state != ST_WAIT),
        .i_enable ((r_state == ST_WAIT) && !ready),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_sel   <= 1'b0;
            r_addr  <= '0;
            r_din   <= '0;
            r_wlo   <= '0;
            r_uds   <= 1'b0;
            r_lds   <= 1'b0;
            r_rnw   <= 1'b1;
            r_long  <= 1'b0;
            r_half  <= 1'b0;
            r_rdata <= '0;
            r_miss  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_sel   <= w_sel;
            r_addr  <= w_addr;
            r_din   <= w_din;
            r_wlo   <= w_wlo;
            r_uds   <= w_uds;
            r_lds   <= w_lds;
            r_rnw   <= w_rnw;
            r_long  <= w_long;
            r_half  <= w_half;
            r_rdata <= w_rdata;
            r_miss  <= w_miss;
            r_err   <= w_err;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_sel       = r_sel;
        w_addr      = r_addr;
        w_din       = r_din;
        w_wlo       = r_wlo;
        w_uds       = r_uds;
        w_lds       = r_lds;
        w_rnw       = r_rnw;
        w_long      = r_long;
        w_half      = r_half;
        w_rdata     = r_rdata;
        w_miss      = 1'b0;
        w_err       = 1'b0;
        w_word_done = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (req) begin
                    w_addr  = {req_addr[23:1], 1'b0};
                    w_rnw   = ~req_wr;
                    w_din   = req_long ? req_wdata[31:16] : req_wdata[15:0];
                    w_wlo   = req_wdata[15:0];
                    w_uds   = req_long | req_uds;
                    w_lds   = req_long | req_lds;
                    w_long  = req_long;
                    w_half  = 1'b0;
                    w_rdata = '0;
                    w_sel   = 1'b1;
                    w_state = ST_CLAIM;
                end
            end
            ST_CLAIM: begin
                if (!sel_ack) begin
                    w_sel   = 1'b0;
                    w_uds   = 1'b0;
                    w_lds   = 1'b0;
                    w_miss  = 1'b1;
                    w_state = ST_IDLE;
                end else if (ready) begin
                    w_word_done = 1'b1;
                end else begin
                    w_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ready) begin
                    w_word_done = 1'b1;
                end else if (w_expire) begin
                    w_sel   = 1'b0;
                    w_uds   = 1'b0;
                    w_lds   = 1'b0;
                    w_err   = 1'b1;
                    w_state = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (r_long && !r_half) begin
                    w_addr  = r_addr + 24'd2;
                    w_din   = r_wlo;
                    w_uds   = 1'b1;
                    w_lds   = 1'b1;
                    w_half  = 1'b1;
                    w_sel   = 1'b1;
                    w_state = ST_CLAIM;
                end else begin
                    w_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state = ST_IDLE;
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase

        // One idle bus cycle between words lets registered responder acks re-arm.
        if (w_word_done) begin
            if (r_rnw) begin
                if (r_long && !r_half) begin
                    w_rdata[31:16] = dout;
                end else begin
                    w_rdata[15:0] = dout;
                end
            end
            w_sel   = 1'b0;
            w_uds   = 1'b0;
            w_lds   = 1'b0;
            w_state = ST_GAP;
        end
    end

    assign busy     = (r_state == ST_CLAIM) || (r_state == ST_WAIT) || (r_state == ST_GAP);
    assign ack      = (r_state == ST_DONE);
    assign miss     = r_miss;
    assign err      = r_err;
    assign rdata    = r_rdata;
    assign sel      = r_sel;
    assign addr     = r_addr;
    assign din      = r_din;
    assign uds      = r_uds;
    assign lds      = r_lds;
    assign rnw      = r_rnw;
    assign longword = r_long;

endmodule
`default_nettype wire
